bcd_xs3_seq_ctrl: RTL and testbench

Sequencing controller that converts a packed multi-digit BCD word to Excess-3 by time-sharing one 4-bit digit converter, one digit per clock. Sits between a BCD producer and an Excess-3 consumer, with valid/ready handshakes on both sides. It trades throughput for area against a fully parallel array of digit converters.

---
 rtl/bcd_xs3_pkg.sv | 16 +
 rtl/bcd_xs3_seq_ctrl_if.sv | 29 ++
 rtl/bcd_digit_xs3.sv | 16 +
 rtl/bcd_xs3_seq_ctrl.sv | 114 +++++++++++
 tb/tb_bcd_xs3_seq_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencing controller.
package bcd_xs3_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] XS3_OFFSET  = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX     = 4'd9;
    localparam logic [DIGIT_W-1:0] XS3_INVALID = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_xs3_seq_ctrl_if.sv
// Producer/consumer handshake bundle for bcd_xs3_seq_ctrl.
import bcd_xs3_pkg::*;

interface bcd_xs3_seq_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = DIGIT_W * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bcd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_xs3;
    logic         out_err;

    // Environment side: drives the word in and takes the result.
    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_xs3, out_err
    );

    // Controller side.
    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_xs3, out_err
    );

endinterface

// File: rtl/bcd_digit_xs3.sv
// Single-digit BCD to Excess-3 converter; digits above 9 map to the invalid code.
import bcd_xs3_pkg::*;

module bcd_digit_xs3 (
    input  logic [DIGIT_W-1:0] bcd,
    output logic [DIGIT_W-1:0] xs3,
    output logic               err
);

    // Offset valid digits, flag and substitute the rest.
    always_comb begin
        err = (bcd > BCD_MAX);
        xs3 = err ? XS3_INVALID : (bcd + XS3_OFFSET);
    end

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Converts a packed BCD word to Excess-3 one digit per clock using a shared
// digit converter. Define BCD_XS3_ERR_EN to report invalid digits on out_err;
// otherwise out_err is tied low.
import bcd_xs3_pkg::*;

module bcd_xs3_seq_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_xs3_seq_ctrl_if.slave bus
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [W-1:0]        src;
    logic [W-1:0]        xs3_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [DIGIT_W-1:0]  dig_in;
    logic [DIGIT_W-1:0]  dig_xs3;
    logic                dig_err;
    logic [DIGIT_W-1:0]  dig_code;

    // Select the source digit addressed by the counter.
    always_comb begin
        dig_in = src[32'(cnt) * DIGIT_W +: DIGIT_W];
    end

    bcd_digit_xs3 u_digit (
        .bcd (dig_in),
        .xs3 (dig_xs3),
        .err (dig_err)
    );

    // Flagged digits always land as the invalid code in the result word.
    always_comb begin
        dig_code = dig_err ? XS3_INVALID : dig_xs3;
    end

    // Sequencer: accept a word, write one digit per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            src         <= '0;
            xs3_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        src        <= bus.in_bcd;
                        xs3_q      <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    xs3_q[32'(cnt) * DIGIT_W +: DIGIT_W] <= dig_code;
                    if (cnt == LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef BCD_XS3_ERR_EN
    logic err_q;

    // Error accumulator: cleared on accept, ORs each converted digit's flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            err_q <= 1'b0;
        end else if (state == CONV) begin
            err_q <= err_q | dig_err;
        end
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_xs3   = xs3_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Directed bench for bcd_xs3_seq_ctrl at DIGITS=4 and DIGITS=1.
// Expected out_err follows BCD_XS3_ERR_EN.
`timescale 1ns/1ps

module tb_bcd_xs3_seq_ctrl;

`ifdef BCD_XS3_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   acc_cyc;
    int   rel_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bcd_xs3_seq_ctrl_if #(.DIGITS(4)) bus4 ();
    bcd_xs3_seq_ctrl_if #(.DIGITS(1)) bus1 ();

    bcd_xs3_seq_ctrl #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    bcd_xs3_seq_ctrl #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word on the 4-digit DUT and hold it until accepted.
    task automatic send4(input logic [15:0] bcd);
        int t = 0;
        @(negedge clk);
        bus4.in_valid = 1'b1;
        bus4.in_bcd   = bcd;
        while (!bus4.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", 32'(t < 50), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
    endtask

    // Wait for out_valid and compare latency (cycles from accept) and payload.
    task automatic result4(input string tag, input logic [15:0] exp_xs3, input logic exp_err);
        int t = 0;
        @(negedge clk);
        while (!bus4.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'd5);
        chk({tag, "_xs3"}, 32'(bus4.out_xs3), 32'(exp_xs3));
        chk({tag, "_err"}, 32'(bus4.out_err), 32'(exp_err));
        chk({tag, "_rdy"}, 32'(bus4.in_ready), 32'd0);
    endtask

    // Take the result on the next edge (called at a negedge with out_valid high).
    task automatic release4();
        bus4.out_ready = 1'b1;
        rel_cyc = cyc;
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b0;
    endtask

    // Full transaction on the single-digit DUT.
    task automatic run1(input string tag, input logic [3:0] bcd, input logic [3:0] exp_xs3,
                        input logic exp_err);
        int t = 0;
        int a;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus1.in_ready), 32'd1);
        bus1.in_valid = 1'b1;
        bus1.in_bcd   = bcd;
        a = cyc;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        while (!bus1.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_lat"}, 32'(cyc - a), 32'd2);
        chk({tag, "_xs3"}, 32'(bus1.out_xs3), 32'(exp_xs3));
        chk({tag, "_err"}, 32'(bus1.out_err), 32'(exp_err));
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, 32'(bus1.in_ready), 32'd1);
        chk({tag, "_idle_vld"}, 32'(bus1.out_valid), 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_bcd    = '0;
        bus4.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_bcd    = '0;
        bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_out_xs3", 32'(bus4.out_xs3), 32'd0);
        chk("rst_out_err", 32'(bus4.out_err), 32'd0);
        chk("rst1_out_valid", 32'(bus1.out_valid), 32'd0);
        rst = 1'b0;

        // Basic word.
        send4(16'h1234);
        result4("w1234", 16'h4567, 1'b0);
        release4();
        @(negedge clk);
        chk("rel_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rel_out_valid", 32'(bus4.out_valid), 32'd0);

        // Boundary digits, then a back-to-back word right after release.
        send4(16'h9009);
        result4("w9009", 16'hC33C, 1'b0);
        release4();
        send4(16'h0000);
        chk("b2b_gap", 32'(acc_cyc - rel_cyc), 32'd1);
        result4("w0000", 16'h3333, 1'b0);
        release4();

        // Invalid digit, then a clean word must clear the error.
        send4(16'h12A4);
        result4("w12A4", 16'h4537, ERR_EN);
        release4();
        send4(16'h5555);
        result4("w5555", 16'h8888, 1'b0);
        release4();

        // Backpressure with a new word held on the input.
        send4(16'h1111);
        result4("w1111", 16'h4444, 1'b0);
        bus4.in_valid = 1'b1;
        bus4.in_bcd   = 16'h0246;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_xs3", 32'(bus4.out_xs3), 32'h4444);
            chk("bp_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        release4();
        @(negedge clk);
        chk("bp_accept_rdy", 32'(bus4.in_ready), 32'd1);
        chk("bp_accept_gap", 32'(cyc - rel_cyc), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        result4("w0246", 16'h3579, 1'b0);
        release4();

        // Reset while converting digit 2 drops the word.
        send4(16'h1234);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("mid_rst_out_xs3", 32'(bus4.out_xs3), 32'd0);
        chk("mid_rst_out_err", 32'(bus4.out_err), 32'd0);
        send4(16'h0987);
        result4("w0987", 16'h3CBA, 1'b0);
        release4();

        // Single-digit configuration.
        run1("d1_7", 4'h7, 4'hA, 1'b0);
        run1("d1_F", 4'hF, 4'h3, ERR_EN);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
